// File: rtl/floppy_track_loader.sv
// ============================================================================
// Module   : floppy_track_loader
// Purpose  : Disk II single-track cache between the controller and SD blocks.
//            Define FDD_WRITEBACK_EN to write dirty tracks back to SD.
// Revision : 1.0
// ============================================================================
`default_nettype none

module floppy_track_loader #(
  parameter int SECTORS_PER_TRACK = 13,
  parameter int BUF_AW            = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              active,
  input  logic [5:0]        track,
  input  logic              img_mounted,
  input  logic [63:0]       img_size,
  output logic [31:0]       lba_fdd,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic [8:0]        sd_buff_addr,
  input  logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_dout,
  output logic [7:0]        sd_buff_din,
  output logic              cpu_wait_fdd,
  input  logic [BUF_AW-1:0] fd_track_addr,
  input  logic              fd_write_disk,
  input  logic [7:0]        fd_data_do,
  output logic [7:0]        fd_data_in
);

  localparam int         BUF_DEPTH = 1 << BUF_AW;
  localparam logic [3:0] LAST_SEC  = 4'(SECTORS_PER_TRACK - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WRITE      = 2'd1,
    S_START_READ = 2'd2,
    S_READ       = 2'd3
  } state_t;

  state_t            r_state;
  logic [7:0]        r_mem [0:BUF_DEPTH-1];
  logic [7:0]        r_sd_buff_din;
  logic [7:0]        r_fd_data_in;
  logic              r_sd_rd;
  logic              r_cpu_wait;
  logic              r_mounted;
  logic              r_reload;
  logic              r_ack_d;
  logic [3:0]        r_track_sec;
  logic [31:0]       r_lba;
  logic [5:0]        r_cur_track;

  logic [BUF_AW-1:0] w_addr_a;
  logic              w_fd_we;
  logic              w_ack_rise;
  logic              w_ack_fall;
  logic [31:0]       w_lba_track;

  assign w_addr_a    = BUF_AW'({r_track_sec, sd_buff_addr});
  assign w_fd_we     = fd_write_disk & active;
  assign w_ack_rise  = sd_ack & ~r_ack_d;
  assign w_ack_fall  = ~sd_ack & r_ack_d;
  assign w_lba_track = 32'(track) * 32'(SECTORS_PER_TRACK);

`ifdef FDD_WRITEBACK_EN
  logic        r_sd_wr;
  logic        r_dirty;
  logic [31:0] w_lba_cur;
  assign w_lba_cur = 32'(r_cur_track) * 32'(SECTORS_PER_TRACK);
  assign sd_wr     = r_sd_wr;
`else
  assign sd_wr     = 1'b0;
`endif

  // Dual-port track buffer; controller port is write-first.
  always_ff @(posedge clk) begin
    if (sd_buff_wr && sd_ack) begin
      r_mem[w_addr_a] <= sd_buff_dout;
    end
    r_sd_buff_din <= r_mem[w_addr_a];
    if (w_fd_we) begin
      r_mem[fd_track_addr] <= fd_data_do;
      r_fd_data_in         <= fd_data_do;
    end else begin
      r_fd_data_in <= r_mem[fd_track_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_sd_rd     <= 1'b0;
      r_cpu_wait  <= 1'b0;
      r_mounted   <= 1'b0;
      r_reload    <= 1'b0;
      r_ack_d     <= 1'b0;
      r_track_sec <= 4'd0;
      r_lba       <= 32'd0;
      r_cur_track <= 6'd0;
`ifdef FDD_WRITEBACK_EN
      r_sd_wr     <= 1'b0;
      r_dirty     <= 1'b0;
`endif
    end else begin
      r_ack_d <= sd_ack;
      case (r_state)
        S_IDLE: begin
          if (r_mounted && ((track != r_cur_track) || r_reload)) begin
`ifdef FDD_WRITEBACK_EN
            if (r_dirty) begin
              r_state     <= S_WRITE;
              r_lba       <= w_lba_cur;
              r_track_sec <= 4'd0;
              r_sd_wr     <= 1'b1;
              r_cpu_wait  <= 1'b1;
              r_dirty     <= 1'b0;
            end else begin
              r_state <= S_START_READ;
            end
`else
            r_state <= S_START_READ;
`endif
          end
        end
`ifdef FDD_WRITEBACK_EN
        S_WRITE: begin
          if (w_ack_rise) begin
            r_lba <= r_lba + 32'd1;
            if (r_track_sec >= LAST_SEC) r_sd_wr <= 1'b0;
          end
          if (w_ack_fall) begin
            r_track_sec <= r_track_sec + 4'd1;
            if (!r_sd_wr) r_state <= S_START_READ;
          end
        end
`endif
        S_START_READ: begin
          r_cur_track <= track;
          r_lba       <= w_lba_track;
          r_track_sec <= 4'd0;
          r_sd_rd     <= 1'b1;
          r_cpu_wait  <= 1'b1;
          r_reload    <= 1'b0;
          r_state     <= S_READ;
        end
        S_READ: begin
          if (w_ack_rise) begin
            r_lba <= r_lba + 32'd1;
            if (r_track_sec >= LAST_SEC) r_sd_rd <= 1'b0;
          end
          if (w_ack_fall) begin
            r_track_sec <= r_track_sec + 4'd1;
            if (!r_sd_rd) begin
              r_cpu_wait <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Mount handling sits after the FSM so a pulse is never lost to a reload clear.
      if (img_mounted) begin
        r_mounted <= |img_size;
        r_reload  <= 1'b1;
      end
`ifdef FDD_WRITEBACK_EN
      if (img_mounted) begin
        r_dirty <= 1'b0;
      end else if (w_fd_we) begin
        r_dirty <= 1'b1;
      end
`endif
    end
  end

  assign lba_fdd      = r_lba;
  assign sd_rd        = r_sd_rd;
  assign cpu_wait_fdd = r_cpu_wait;
  assign sd_buff_din  = r_sd_buff_din;
  assign fd_data_in   = r_fd_data_in;

endmodule

`default_nettype wire

// File: tb/tb_floppy_track_loader.sv
// ============================================================================
// Module   : tb_floppy_track_loader
// Purpose  : Directed + randomized bench with an SD image model and track model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_floppy_track_loader;

  localparam int SPT       = 13;
  localparam int TRACK_LEN = SPT * 512;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        active = 1'b0;
  logic [5:0]  track = 6'd0;
  logic        img_mounted = 1'b0;
  logic [63:0] img_size = 64'd0;
  logic [31:0] lba_fdd;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = 9'd0;
  logic        sd_buff_wr = 1'b0;
  logic [7:0]  sd_buff_dout = 8'd0;
  logic [7:0]  sd_buff_din;
  logic        cpu_wait_fdd;
  logic [13:0] fd_track_addr = 14'd0;
  logic        fd_write_disk = 1'b0;
  logic [7:0]  fd_data_do = 8'd0;
  logic [7:0]  fd_data_in;

  int checks = 0;
  int errors = 0;

  // Reference model: SD image contents, expected track buffer, loader bookkeeping.
  logic [7:0]  disk [int];
  logic [7:0]  mbuf [0:TRACK_LEN-1];
  int          mcur = 0;
  bit          mdirty = 1'b0;
  int unsigned seed;

  floppy_track_loader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .active        (active),
    .track         (track),
    .img_mounted   (img_mounted),
    .img_size      (img_size),
    .lba_fdd       (lba_fdd),
    .sd_rd         (sd_rd),
    .sd_wr         (sd_wr),
    .sd_ack        (sd_ack),
    .sd_buff_addr  (sd_buff_addr),
    .sd_buff_wr    (sd_buff_wr),
    .sd_buff_dout  (sd_buff_dout),
    .sd_buff_din   (sd_buff_din),
    .cpu_wait_fdd  (cpu_wait_fdd),
    .fd_track_addr (fd_track_addr),
    .fd_write_disk (fd_write_disk),
    .fd_data_do    (fd_data_do),
    .fd_data_in    (fd_data_in)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Track 0 holds the offset pattern; other sectors get a seed-dependent pattern.
  function automatic logic [7:0] dbyte(input int lba, input int off);
    int unsigned h;
    if (disk.exists(lba * 512 + off)) return disk[lba * 512 + off];
    if (lba < SPT) return 8'(off);
    h = (32'(lba) * seed) >> 3;
    return 8'(off) ^ 8'(h);
  endfunction

  // Emulates the SD host side for up to max_sec sectors of one transfer.
  task automatic serve(input bit is_wr, input int lba0, input int max_sec, output int nsec);
    int t;
    int lba_bad;
    int data_bad;
    logic [7:0] b;
    nsec = 0; lba_bad = 0; data_bad = 0; t = 0;
    while (!(sd_rd || sd_wr) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("xfer_req_is_write", {31'd0, sd_wr}, {31'd0, is_wr});
    check("xfer_cpu_wait", {31'd0, cpu_wait_fdd}, 32'd1);
    while ((is_wr ? sd_wr : sd_rd) && nsec < max_sec) begin
      if (lba_fdd !== 32'(lba0 + nsec)) lba_bad++;
      sd_ack = 1'b1;
      for (int i = 0; i <= 512; i++) begin
        if (is_wr) begin
          if (i > 0) begin
            b = sd_buff_din;
            disk[(lba0 + nsec) * 512 + i - 1] = b;
            if (b !== mbuf[nsec * 512 + i - 1]) data_bad++;
          end
          if (i < 512) sd_buff_addr = 9'(i);
        end else if (i < 512) begin
          b = dbyte(lba0 + nsec, i);
          sd_buff_addr = 9'(i);
          sd_buff_dout = b;
          sd_buff_wr   = 1'b1;
          mbuf[nsec * 512 + i] = b;
        end
        if (i < 512) @(negedge clk);
      end
      sd_buff_wr = 1'b0;
      sd_ack     = 1'b0;
      repeat (2) @(negedge clk);
      nsec++;
    end
    check("xfer_lba_sequence_bad", lba_bad, 0);
    if (is_wr) check("wb_data_bad_bytes", data_bad, 0);
  endtask

  task automatic expect_reload(input int newt);
    int n;
`ifdef FDD_WRITEBACK_EN
    if (mdirty) begin
      serve(1'b1, mcur * SPT, SPT, n);
      check("wb_sector_count", n, SPT);
    end
`endif
    mdirty = 1'b0;
    serve(1'b0, newt * SPT, SPT, n);
    check("rd_sector_count", n, SPT);
    mcur = newt;
    check("rd_cpu_wait_released", {31'd0, cpu_wait_fdd}, 32'd0);
    check("rd_final_lba", lba_fdd, 32'(newt * SPT + SPT));
    check("rd_sd_rd_low", {31'd0, sd_rd}, 32'd0);
  endtask

  task automatic cpu_write(input int a, input logic [7:0] d, input bit act);
    @(negedge clk);
    fd_track_addr = 14'(a);
    fd_data_do    = d;
    active        = act;
    fd_write_disk = 1'b1;
    @(negedge clk);
    fd_write_disk = 1'b0;
    active        = 1'b0;
    if (act) begin
      mbuf[a] = d;
      mdirty  = 1'b1;
    end
  endtask

  task automatic cpu_read(input int a, input string tag);
    @(negedge clk);
    fd_track_addr = 14'(a);
    fd_write_disk = 1'b0;
    @(negedge clk);
    check(tag, {24'd0, fd_data_in}, {24'd0, mbuf[a]});
  endtask

  task automatic mount(input logic [63:0] sz);
    @(negedge clk);
    img_size    = sz;
    img_mounted = 1'b1;
    @(negedge clk);
    img_mounted = 1'b0;
    mdirty      = 1'b0;
  endtask

  initial begin
    int n;
    int nt;
    seed = $urandom | 32'd1;

    repeat (3) @(negedge clk);
    check("reset_sd_rd", {31'd0, sd_rd}, 32'd0);
    check("reset_sd_wr", {31'd0, sd_wr}, 32'd0);
    check("reset_cpu_wait", {31'd0, cpu_wait_fdd}, 32'd0);
    check("reset_lba", lba_fdd, 32'd0);
    reset_n = 1'b1;

    // Unmounted drive ignores head movement.
    track = 6'd5;
    repeat (20) @(negedge clk);
    check("unmounted_no_read", {31'd0, sd_rd}, 32'd0);
    track = 6'd0;

    mount(64'd143360);
    expect_reload(0);
    @(negedge clk);
    fd_track_addr = 14'h0205;
    @(negedge clk);
    check("track0_byte_0205", {24'd0, fd_data_in}, 32'h05);
    for (int i = 0; i < 4; i++) cpu_read($urandom_range(0, TRACK_LEN - 1), "track0_rand_read");

    track = 6'd17;
    expect_reload(17);
    for (int i = 0; i < 4; i++) cpu_read($urandom_range(0, TRACK_LEN - 1), "track17_rand_read");

    cpu_write(16'h0010, 8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) cpu_write($urandom_range(32, TRACK_LEN - 1), 8'($urandom), 1'b1);
    cpu_read(16'h0010, "write_through_0010");
    track = 6'd3;
    expect_reload(3);
`ifdef FDD_WRITEBACK_EN
    check("wb_byte_a5_on_sd", {24'd0, dbyte(17 * SPT, 16)}, 32'hA5);
`endif

    cpu_write(16'h0010, 8'h5A, 1'b0);
    cpu_read(16'h0010, "inactive_write_ignored");
    track = 6'd17;
    expect_reload(17);
    cpu_read(16'h0010, "track17_reload_0010");
`ifdef FDD_WRITEBACK_EN
    check("track17_kept_a5", {24'd0, fd_data_in}, 32'hA5);
`endif

    for (int it = 0; it < 2; it++) begin
      do nt = $urandom_range(0, 34); while (nt == mcur);
      for (int w = 0; w < 3; w++)
        cpu_write($urandom_range(0, TRACK_LEN - 1), 8'($urandom), 1'($urandom_range(0, 1)));
      track = 6'(nt);
      expect_reload(nt);
      for (int i = 0; i < 3; i++) cpu_read($urandom_range(0, TRACK_LEN - 1), "rand_track_read");
    end

    // Reset in the middle of a read.
    nt = (mcur + 7) % 35;
    track = 6'(nt);
    serve(1'b0, nt * SPT, 5, n);
    check("partial_sector_count", n, 5);
    check("partial_still_reading", {31'd0, sd_rd}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_sd_rd", {31'd0, sd_rd}, 32'd0);
    check("abort_cpu_wait", {31'd0, cpu_wait_fdd}, 32'd0);
    check("abort_lba", lba_fdd, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    mount(64'd0);
    track = 6'((nt + 3) % 35);
    repeat (30) @(negedge clk);
    check("empty_mount_no_read", {31'd0, sd_rd}, 32'd0);
    check("empty_mount_no_write", {31'd0, sd_wr}, 32'd0);
    check("empty_mount_no_wait", {31'd0, cpu_wait_fdd}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
